// File: rtl/d_arb.sv
// d_arb: two-master round-robin arbiter for the data-side bus.
// One transaction per grant, with a per-transaction watchdog that terminates
// stalled accesses with an error. While a grant is held, the owner's request
// passes straight through to the decoder and the decoder's completion passes
// straight back to the owner.
module d_arb #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 14,
  parameter int TIMEOUT  = 15   // legal range 2..255, counted in 8 bits
) (
  input  logic                clk,
  input  logic                rst,
  // master 0 (CPU load/store unit)
  input  logic [ADDR_LEN-1:0] m0_addr,
  input  logic                m0_rd_req,
  input  logic                m0_wr_req,
  input  logic [XLEN/8-1:0]   m0_wr_be,
  input  logic [XLEN-1:0]     m0_wr_data,
  output logic [XLEN-1:0]     m0_rd_data,
  output logic                m0_rd_ready,
  output logic                m0_wr_ready,
  output logic                m0_err,
  // master 1 (debug / DMA)
  input  logic [ADDR_LEN-1:0] m1_addr,
  input  logic                m1_rd_req,
  input  logic                m1_wr_req,
  input  logic [XLEN/8-1:0]   m1_wr_be,
  input  logic [XLEN-1:0]     m1_wr_data,
  output logic [XLEN-1:0]     m1_rd_data,
  output logic                m1_rd_ready,
  output logic                m1_wr_ready,
  output logic                m1_err,
  // downstream (address decoder)
  output logic [ADDR_LEN-1:0] d_addr,
  output logic                d_rd_req,
  output logic                d_wr_req,
  output logic [XLEN/8-1:0]   d_wr_be,
  output logic [XLEN-1:0]     d_wr_data,
  input  logic                d_rd_ready,
  input  logic                d_wr_ready,
  input  logic [XLEN-1:0]     d_rd_data,
  // status
  output logic [1:0]          grant,
  output logic                busy
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  // Last BUSY cycle index before the watchdog fires.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              r_state, w_state_next;
  logic                r_gnt, w_gnt_next;     // current owner (0 = m0, 1 = m1)
  logic                r_last, w_last_next;   // previous owner, for round-robin
  logic [7:0]          r_cnt, w_cnt_next;     // BUSY cycles elapsed

  logic                w_busy;
  logic                w_req0, w_req1;
  logic                w_own_rd, w_own_wr;
  logic                w_fwd_rd, w_fwd_wr;
  logic                w_done;
  logic                w_own_rd_ready, w_own_wr_ready, w_own_err;
  logic [XLEN-1:0]     w_own_rd_data;

  assign w_busy   = (r_state == S_BUSY);
  assign w_req0   = m0_rd_req | m0_wr_req;
  assign w_req1   = m1_rd_req | m1_wr_req;
  assign w_own_rd = r_gnt ? m1_rd_req : m0_rd_req;
  assign w_own_wr = r_gnt ? m1_wr_req : m0_wr_req;

  // A simultaneous read+write from the owner forwards only the write.
  assign w_fwd_wr = w_busy & w_own_wr;
  assign w_fwd_rd = w_busy & w_own_rd & ~w_own_wr;
  assign w_done   = (w_fwd_wr & d_wr_ready) | (w_fwd_rd & d_rd_ready);

  // Downstream request: the owner's fields in BUSY, all zero in IDLE.
  assign d_rd_req  = w_fwd_rd;
  assign d_wr_req  = w_fwd_wr;
  assign d_addr    = w_busy ? (r_gnt ? m1_addr    : m0_addr)    : '0;
  assign d_wr_be   = w_busy ? (r_gnt ? m1_wr_be   : m0_wr_be)   : '0;
  assign d_wr_data = w_busy ? (r_gnt ? m1_wr_data : m0_wr_data) : '0;

  // Owner-side strobes are steered to the owning master only.
  assign m0_rd_ready = w_own_rd_ready & ~r_gnt;
  assign m0_wr_ready = w_own_wr_ready & ~r_gnt;
  assign m0_err      = w_own_err      & ~r_gnt;
  assign m0_rd_data  = r_gnt ? '0 : w_own_rd_data;
  assign m1_rd_ready = w_own_rd_ready & r_gnt;
  assign m1_wr_ready = w_own_wr_ready & r_gnt;
  assign m1_err      = w_own_err      & r_gnt;
  assign m1_rd_data  = r_gnt ? w_own_rd_data : '0;

  assign grant = {w_busy & r_gnt, w_busy & ~r_gnt};
  assign busy  = w_busy;

  // State register: owner, round-robin pointer and watchdog counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;   // m0 wins the first tie after reset
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_last  <= w_last_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic: arbitration in IDLE; completion, abandon and watchdog in BUSY.
  always_comb begin
    w_state_next   = r_state;
    w_gnt_next     = r_gnt;
    w_last_next    = r_last;
    w_cnt_next     = r_cnt;
    w_own_rd_ready = 1'b0;
    w_own_wr_ready = 1'b0;
    w_own_err      = 1'b0;
    w_own_rd_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req0 | w_req1) begin
          // On a tie the master that did not go last wins.
          w_gnt_next   = (w_req0 & w_req1) ? ~r_last : w_req1;
          w_last_next  = w_gnt_next;
          w_cnt_next   = 8'd0;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        w_own_rd_data = d_rd_data;
        if (w_done) begin
          w_own_rd_ready = w_fwd_rd;
          w_own_wr_ready = w_fwd_wr;
          w_state_next   = S_IDLE;
        end else if (!(w_own_rd | w_own_wr)) begin
          // Owner abandoned the access: release silently.
          w_state_next = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          // Watchdog: terminate with ready+err and no read data.
          w_own_rd_ready = w_fwd_rd;
          w_own_wr_ready = w_fwd_wr;
          w_own_err      = 1'b1;
          w_own_rd_data  = '0;
          w_state_next   = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_d_arb.sv
// tb_d_arb: directed self-checking bench for d_arb.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. "Cycle T" is the IDLE cycle in which a request is first seen.
`timescale 1ns/1ps
module tb_d_arb;

  localparam int XLEN     = 32;
  localparam int ADDR_LEN = 14;
  localparam int TIMEOUT  = 15;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [ADDR_LEN-1:0] m0_addr, m1_addr;
  logic                m0_rd_req, m0_wr_req, m1_rd_req, m1_wr_req;
  logic [XLEN/8-1:0]   m0_wr_be, m1_wr_be;
  logic [XLEN-1:0]     m0_wr_data, m1_wr_data;
  logic [XLEN-1:0]     m0_rd_data, m1_rd_data;
  logic                m0_rd_ready, m0_wr_ready, m0_err;
  logic                m1_rd_ready, m1_wr_ready, m1_err;
  logic [ADDR_LEN-1:0] d_addr;
  logic                d_rd_req, d_wr_req;
  logic [XLEN/8-1:0]   d_wr_be;
  logic [XLEN-1:0]     d_wr_data;
  logic                d_rd_ready, d_wr_ready;
  logic [XLEN-1:0]     d_rd_data;
  logic [1:0]          grant;
  logic                busy;

  // Downstream read-ready source: directed value, or a RAM-like responder
  // that answers one cycle after it sees d_rd_req.
  logic ram_mode;
  logic drv_rd_ready;
  logic ram_rdy_q;
  assign d_rd_ready = ram_mode ? ram_rdy_q : drv_rd_ready;

  always @(posedge clk) begin
    if (rst) ram_rdy_q <= 1'b0;
    else     ram_rdy_q <= d_rd_req;
  end

  int n_tests = 0;
  int n_fail  = 0;

  wire [124:0] all_out = {d_addr, d_rd_req, d_wr_req, d_wr_be, d_wr_data, grant, busy,
                          m0_rd_data, m0_rd_ready, m0_wr_ready, m0_err,
                          m1_rd_data, m1_rd_ready, m1_wr_ready, m1_err};

  d_arb #(.XLEN(XLEN), .ADDR_LEN(ADDR_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_rd_req(m0_rd_req), .m0_wr_req(m0_wr_req),
    .m0_wr_be(m0_wr_be), .m0_wr_data(m0_wr_data), .m0_rd_data(m0_rd_data),
    .m0_rd_ready(m0_rd_ready), .m0_wr_ready(m0_wr_ready), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req),
    .m1_wr_be(m1_wr_be), .m1_wr_data(m1_wr_data), .m1_rd_data(m1_rd_data),
    .m1_rd_ready(m1_rd_ready), .m1_wr_ready(m1_wr_ready), .m1_err(m1_err),
    .d_addr(d_addr), .d_rd_req(d_rd_req), .d_wr_req(d_wr_req),
    .d_wr_be(d_wr_be), .d_wr_data(d_wr_data),
    .d_rd_ready(d_rd_ready), .d_wr_ready(d_wr_ready), .d_rd_data(d_rd_data),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    m0_addr = '0; m0_rd_req = 0; m0_wr_req = 0; m0_wr_be = '0; m0_wr_data = '0;
    m1_addr = '0; m1_rd_req = 0; m1_wr_req = 0; m1_wr_be = '0; m1_wr_data = '0;
    d_wr_ready = 0; d_rd_data = '0; drv_rd_ready = 0; ram_mode = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Leaves the bench 1 unit after the edge that opens cycle T, reset released.
  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    m0_rd_req = 1; m1_rd_req = 1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    sample();
    n_tests++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL reset_grant: got %b want 00", grant);
    end
    next_cycle();
    rst = 1'b0;
    sample();
    n_tests++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_release_idle: got %h want 0", all_out);
    end
    next_cycle();
    sample();
    n_tests++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL reset_first_grant: got %b want 01", grant);
    end
    $display("[TB] reset: grant after release %b", grant);
  endtask

  task automatic test_single_write();
    do_reset();
    d_wr_ready = 1;
    m0_wr_req = 1; m0_addr = 14'h1000; m0_wr_be = 4'hF; m0_wr_data = 32'hA5A5A5A5;
    sample();
    n_tests++;
    if (d_wr_req !== 1'b0 || grant !== 2'b00) begin
      n_fail++; $display("FAIL write_T: d_wr_req=%b grant=%b want 0/00", d_wr_req, grant);
    end
    next_cycle();
    sample();
    n_tests++;
    if (d_wr_req !== 1'b1 || d_rd_req !== 1'b0 || d_addr !== 14'h1000 ||
        d_wr_be !== 4'hF || d_wr_data !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL write_fwd: wr=%b rd=%b addr=%h be=%h data=%h want 1/0/1000/f/a5a5a5a5",
                         d_wr_req, d_rd_req, d_addr, d_wr_be, d_wr_data);
    end
    n_tests++;
    if (m0_wr_ready !== 1'b1 || m0_err !== 1'b0 || m1_wr_ready !== 1'b0 ||
        grant !== 2'b01 || busy !== 1'b1) begin
      n_fail++; $display("FAIL write_ready: m0_wr_ready=%b m0_err=%b m1_wr_ready=%b grant=%b busy=%b want 1/0/0/01/1",
                         m0_wr_ready, m0_err, m1_wr_ready, grant, busy);
    end
    next_cycle();
    m0_wr_req = 0;
    sample();
    n_tests++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL write_release: grant=%b busy=%b want 00/0", grant, busy);
    end
    $display("[TB] single write: addr 1000 data a5a5a5a5 done");
  endtask

  task automatic test_ram_read();
    do_reset();
    ram_mode = 1; d_rd_data = 32'h12345678;
    m1_rd_req = 1; m1_addr = 14'h0040;
    sample();
    n_tests++;
    if (m0_rd_data !== '0 || m1_rd_ready !== 1'b0) begin
      n_fail++; $display("FAIL read_T: m0_rd_data=%h m1_rd_ready=%b want 0/0", m0_rd_data, m1_rd_ready);
    end
    next_cycle();
    sample();
    n_tests++;
    if (d_rd_req !== 1'b1 || d_addr !== 14'h0040 || m1_rd_ready !== 1'b0 ||
        grant !== 2'b10 || m0_rd_data !== '0) begin
      n_fail++; $display("FAIL read_T1: d_rd_req=%b addr=%h m1_rd_ready=%b grant=%b m0_rd_data=%h want 1/0040/0/10/0",
                         d_rd_req, d_addr, m1_rd_ready, grant, m0_rd_data);
    end
    next_cycle();
    sample();
    n_tests++;
    if (m1_rd_ready !== 1'b1 || m1_rd_data !== 32'h12345678 || m1_err !== 1'b0 ||
        m0_rd_data !== '0 || m0_rd_ready !== 1'b0) begin
      n_fail++; $display("FAIL read_T2: m1_rd_ready=%b m1_rd_data=%h m1_err=%b m0_rd_data=%h m0_rd_ready=%b want 1/12345678/0/0/0",
                         m1_rd_ready, m1_rd_data, m1_err, m0_rd_data, m0_rd_ready);
    end
    next_cycle();
    m1_rd_req = 0;
    sample();
    n_tests++;
    if (grant !== 2'b00 || m1_rd_data !== '0) begin
      n_fail++; $display("FAIL read_release: grant=%b m1_rd_data=%h want 00/0", grant, m1_rd_data);
    end
    $display("[TB] ram read: m1 got %h", 32'h12345678);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    logic       exp_r0, exp_r1;
    do_reset();
    ram_mode = 1; d_rd_data = 32'h0BADF00D;
    m0_rd_req = 1; m1_rd_req = 1;
    m0_addr = 14'h0100; m1_addr = 14'h0200;
    for (int i = 0; i < 12; i++) begin
      // Each transaction is IDLE, BUSY (wait), BUSY (ready); owners alternate.
      exp_g  = ((i % 3) == 0) ? 2'b00 : (((i / 3) % 2) == 0 ? 2'b01 : 2'b10);
      exp_r0 = ((i % 3) == 2) && (((i / 3) % 2) == 0);
      exp_r1 = ((i % 3) == 2) && (((i / 3) % 2) == 1);
      sample();
      n_tests++;
      if (grant !== exp_g || m0_rd_ready !== exp_r0 || m1_rd_ready !== exp_r1) begin
        n_fail++; $display("FAIL rr_cycle%0d: grant=%b r0=%b r1=%b want %b/%b/%b",
                           i, grant, m0_rd_ready, m1_rd_ready, exp_g, exp_r0, exp_r1);
      end
      next_cycle();
    end
    m0_rd_req = 0; m1_rd_req = 0;
    $display("[TB] round robin: 12 cycles checked");
  endtask

  task automatic test_timeout();
    do_reset();
    drv_rd_ready = 0; d_rd_data = 32'hDEADBEEF;
    m0_rd_req = 1; m1_rd_req = 1;
    sample();
    n_tests++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL to_T: grant=%b want 00", grant);
    end
    next_cycle();
    for (int k = 1; k < TIMEOUT; k++) begin
      sample();
      n_tests++;
      if (m0_rd_ready !== 1'b0 || m0_err !== 1'b0 || grant !== 2'b01) begin
        n_fail++; $display("FAIL to_wait%0d: ready=%b err=%b grant=%b want 0/0/01",
                           k, m0_rd_ready, m0_err, grant);
      end
      next_cycle();
    end
    sample();
    n_tests++;
    if (m0_rd_ready !== 1'b1 || m0_err !== 1'b1 || m0_rd_data !== '0 ||
        m1_rd_ready !== 1'b0 || m1_err !== 1'b0) begin
      n_fail++; $display("FAIL to_fire: ready=%b err=%b data=%h m1_ready=%b m1_err=%b want 1/1/0/0/0",
                         m0_rd_ready, m0_err, m0_rd_data, m1_rd_ready, m1_err);
    end
    next_cycle();
    m0_rd_req = 0;
    sample();
    n_tests++;
    if (grant !== 2'b00 || m0_err !== 1'b0) begin
      n_fail++; $display("FAIL to_idle: grant=%b err=%b want 00/0", grant, m0_err);
    end
    next_cycle();
    sample();
    n_tests++;
    if (grant !== 2'b10) begin
      n_fail++; $display("FAIL to_next_owner: grant=%b want 10", grant);
    end
    next_cycle();
    m1_rd_req = 0;
    $display("[TB] timeout: err after %0d busy cycles", TIMEOUT);
  endtask

  task automatic test_back_to_back();
    do_reset();
    d_wr_ready = 1;
    m0_wr_req = 1; m0_addr = 14'h0008; m0_wr_be = 4'h3; m0_wr_data = 32'h00001111;
    for (int i = 0; i < 8; i++) begin
      sample();
      n_tests++;
      if (m0_wr_ready !== 1'(i % 2) || grant !== ((i % 2) == 1 ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL b2b_cycle%0d: wr_ready=%b grant=%b want %0d/%s",
                           i, m0_wr_ready, grant, i % 2, (i % 2) == 1 ? "01" : "00");
      end
      next_cycle();
    end
    m0_wr_req = 0;
    $display("[TB] back to back: one write per 2 cycles");
  endtask

  task automatic test_rd_wr_both();
    do_reset();
    m0_rd_req = 1; m0_wr_req = 1; m0_wr_data = 32'hCAFEF00D; m0_wr_be = 4'hC;
    next_cycle();
    sample();
    n_tests++;
    if (d_wr_req !== 1'b1 || d_rd_req !== 1'b0 || d_wr_data !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL rdwr_fwd: d_wr_req=%b d_rd_req=%b data=%h want 1/0/cafef00d",
                         d_wr_req, d_rd_req, d_wr_data);
    end
    next_cycle();
    d_wr_ready = 1; drv_rd_ready = 1;
    sample();
    n_tests++;
    if (m0_wr_ready !== 1'b1 || m0_rd_ready !== 1'b0) begin
      n_fail++; $display("FAIL rdwr_ready: wr_ready=%b rd_ready=%b want 1/0", m0_wr_ready, m0_rd_ready);
    end
    next_cycle();
    m0_rd_req = 0; m0_wr_req = 0;
    $display("[TB] rd+wr together: write forwarded");
  endtask

  task automatic test_drop();
    do_reset();
    m1_wr_req = 1; m1_wr_data = 32'h55AA55AA;
    next_cycle();
    sample();
    n_tests++;
    if (grant !== 2'b10 || d_wr_req !== 1'b1) begin
      n_fail++; $display("FAIL drop_busy: grant=%b d_wr_req=%b want 10/1", grant, d_wr_req);
    end
    next_cycle();
    m1_wr_req = 0;
    sample();
    n_tests++;
    if (m1_wr_ready !== 1'b0 || m1_err !== 1'b0 || d_wr_req !== 1'b0) begin
      n_fail++; $display("FAIL drop_strobes: wr_ready=%b err=%b d_wr_req=%b want 0/0/0",
                         m1_wr_ready, m1_err, d_wr_req);
    end
    next_cycle();
    sample();
    n_tests++;
    if (grant !== 2'b00 || busy !== 1'b0 || m1_err !== 1'b0) begin
      n_fail++; $display("FAIL drop_idle: grant=%b busy=%b err=%b want 00/0/0", grant, busy, m1_err);
    end
    $display("[TB] drop: owner abandoned, released silently");
  endtask

  task automatic test_rst_mid_busy();
    do_reset();
    m0_rd_req = 1; m0_addr = 14'h0123;
    next_cycle();
    sample();
    n_tests++;
    if (busy !== 1'b1 || d_rd_req !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_busy: busy=%b d_rd_req=%b want 1/1", busy, d_rd_req);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h want 0", all_out);
    end
    next_cycle();
    clear_inputs();
    rst = 1'b0;
    sample();
    n_tests++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL rstmid_after: got %h want 0", all_out);
    end
    $display("[TB] reset mid-busy: transaction aborted");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_ram_read();
    test_round_robin();
    test_timeout();
    test_back_to_back();
    test_rd_wr_both();
    test_drop();
    test_rst_mid_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
